// File: rtl/quadrature_wheel_decoder.sv
// Quadrature wheel front end: sync, glitch filter, direction decode, step pulses.
// Define QUAD_X4_EN for x4 decoding; default build decodes x1.
module quadrature_wheel_decoder #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enc_a,
   input  logic enc_b,
   input  logic enable,
   input  logic clr_erro,
   output logic conta_CW,
   output logic conta_CWW,
   output logic sentido,
   output logic erro
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_LEN - 1);

   typedef enum logic [1:0] {
      S00 = 2'b00,
      S01 = 2'b01,
      S10 = 2'b10,
      S11 = 2'b11
   } state_t;

   logic a_m, a_s, b_m, b_s;
   logic fa, fb;
   logic [CNT_W-1:0] cnt_a, cnt_b;
   state_t state;
   logic [1:0] pair;
   logic step_cw, step_cww, illegal;
   logic pulse_cw, pulse_cww;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_m <= 1'b0;
         a_s <= 1'b0;
         b_m <= 1'b0;
         b_s <= 1'b0;
      end else begin
         a_m <= enc_a;
         a_s <= a_m;
         b_m <= enc_b;
         b_s <= b_m;
      end
   end

   // A new level is accepted on the FILTER_LEN-th consecutive mismatch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fa    <= 1'b0;
         cnt_a <= '0;
      end else if (a_s == fa) begin
         cnt_a <= '0;
      end else if (cnt_a == LAST) begin
         fa    <= a_s;
         cnt_a <= '0;
      end else begin
         cnt_a <= cnt_a + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fb    <= 1'b0;
         cnt_b <= '0;
      end else if (b_s == fb) begin
         cnt_b <= '0;
      end else if (cnt_b == LAST) begin
         fb    <= b_s;
         cnt_b <= '0;
      end else begin
         cnt_b <= cnt_b + 1'b1;
      end
   end

   always_comb begin
      pair     = {fa, fb};
      step_cw  = 1'b0;
      step_cww = 1'b0;
      unique case (state)
         S00: begin
            step_cw  = (pair == 2'b10);
            step_cww = (pair == 2'b01);
         end
         S10: begin
            step_cw  = (pair == 2'b11);
            step_cww = (pair == 2'b00);
         end
         S11: begin
            step_cw  = (pair == 2'b01);
            step_cww = (pair == 2'b10);
         end
         S01: begin
            step_cw  = (pair == 2'b00);
            step_cww = (pair == 2'b11);
         end
         default: begin
            step_cw  = 1'b0;
            step_cww = 1'b0;
         end
      endcase
      illegal = ((state ^ pair) == 2'b11);
`ifdef QUAD_X4_EN
      pulse_cw  = step_cw;
      pulse_cww = step_cww;
`else
      pulse_cw  = step_cw && (state == S01);
      pulse_cww = step_cww && (state == S10);
`endif
   end

   // FSM always follows the filtered pair, even across an illegal jump.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S00;
         conta_CW  <= 1'b0;
         conta_CWW <= 1'b0;
         sentido   <= 1'b0;
         erro      <= 1'b0;
      end else begin
         state     <= state_t'(pair);
         conta_CW  <= enable && pulse_cw;
         conta_CWW <= enable && pulse_cww;
         if (enable && step_cw)
            sentido <= 1'b0;
         else if (enable && step_cww)
            sentido <= 1'b1;
         if (illegal)
            erro <= 1'b1;
         else if (clr_erro)
            erro <= 1'b0;
      end
   end

endmodule

// File: doc/quadrature_wheel_decoder.md
# quadrature_wheel_decoder

Upstream front end of the wheel-position datapath. Samples the two raw quadrature encoder channels of the wheel, synchronizes and glitch-filters them, and decodes direction. Emits single-cycle `conta_CW` / `conta_CWW` step pulses that drive the CW and CWW step counters of the wheel interface datapath directly. Flags illegal encoder transitions.

## Interface
- `FILTER_LEN`, 4: consecutive clock cycles a synchronized channel must hold a new level before it is accepted; legal range 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears every register immediately.
- `enc_a`  in  1  raw encoder channel A; asynchronous to `clk`.
- `enc_b`  in  1  raw encoder channel B; asynchronous to `clk`.
- `enable`  in  1  when low, the decoder still tracks the encoder but emits no step pulses.
- `clr_erro`  in  1  synchronous clear of `erro`.
- `conta_CW`  out  1  one-cycle pulse per clockwise step.
- `conta_CWW`  out  1  one-cycle pulse per counter-clockwise step.
- `sentido`  out  1  direction of the last accepted step: 0 = CW, 1 = CWW.
- `erro`  out  1  sticky flag; set by an illegal two-bit jump.

## Operation
- **Synchronizer:** two flip-flop stages per channel, producing `a_s` and `b_s`. Both stages reset to 0.
- **Glitch filter (per channel):**
  - Holds a filtered level `f` (reset 0) and a counter (reset 0), width ceil(log2(FILTER_LEN+1)).
  - If the synchronized level equals `f`: counter is cleared.
  - Otherwise: counter increments. On the edge where the count would reach FILTER_LEN, `f` takes the new level and the counter is cleared.
  - A mismatch that breaks before FILTER_LEN consecutive cycles changes nothing.
- **Decoder FSM:**
  - Four states mirror the previous filtered pair {A,B}: S00, S10, S11, S01. Reset state is S00.
  - CW order: S00→S10→S11→S01→S00.
  - CWW order: S00→S01→S11→S10→S00.
  - Each cycle the FSM compares the current {fA,fB} with its state, then moves to {fA,fB} unconditionally.
- **Step classification:**
  - No change: no pulse.
  - One-step change in CW order: CW step.
  - One-step change in CWW order: CWW step.
  - Both bits change in the same cycle: illegal. `erro` is set, no pulse is emitted, `sentido` is unchanged, and the FSM resynchronizes to the new pair.
- **Outputs:**
  - A CW step with `enable`=1 registers `conta_CW`=1 for exactly one cycle and sets `sentido`=0.
  - A CWW step with `enable`=1 registers `conta_CWW`=1 for exactly one cycle and sets `sentido`=1.
  - With `enable`=0, steps update the FSM but produce no pulses and no `sentido` change. Illegal jumps still set `erro`.
  - `conta_CW` and `conta_CWW` are never high in the same cycle.
- **`erro`:** cleared only by reset or by `clr_erro`=1. If `clr_erro`=1 and an illegal jump occur in the same cycle, set wins.
- **Reset values:** all outputs 0; FSM in S00; both filters at level 0 with counter 0.

## Timing
- Let edge k be the first rising edge at which the synchronizer's first stage captures a new channel level that then stays stable.
- The filtered level changes at edge k+1+FILTER_LEN.
- The step pulse is high between edges k+2+FILTER_LEN and k+3+FILTER_LEN: latency FILTER_LEN+2 edges.
- Example: FILTER_LEN=1 gives a latency of 3 edges.
- Minimum resolvable step spacing is FILTER_LEN cycles. Faster edges are filtered out and never reach the FSM.
- If the two channels' filtered levels update on the same edge, the change is classified as an illegal jump.
- Asserting `reset` mid-operation immediately clears any pulse in flight and the error flag. After release, the first edges compare against S00.

## Configuration
- Macro: `QUAD_X4_EN`.
- Defined: x4 decoding. Every legal single-bit transition produces one pulse, giving 4 pulses per encoder period.
- Undefined: x1 decoding.
  - Only S01→S00 produces `conta_CW`, and only S10→S00 produces `conta_CWW`.
  - All other legal transitions update the FSM and `sentido` silently.
  - Illegal-jump detection is identical in both modes.

## Test plan
- **Reset:** `reset`=0, inputs toggling → all outputs 0. Release `reset` with A=B=0 held → no pulses for 20 cycles.
- **CW period:** FILTER_LEN=4, x4 mode, full CW sequence on {A,B} with each level held 10 cycles → 4 `conta_CW` pulses, each 1 cycle wide. Each pulse appears 6 edges after its input edge is first sampled. `sentido`=0, no `conta_CWW`.
- **CWW period:** same stimulus in CWW order, x4 mode → 4 `conta_CWW` pulses. Repeated with `QUAD_X4_EN` undefined → exactly 1 pulse, on the S10→S00 transition. `sentido`=1.
- **Glitch rejection:** FILTER_LEN=4, 3-cycle high glitch on A → no pulse, filtered A unchanged. A 4-cycle-or-longer high on A → one `conta_CW` pulse.
- **Illegal jump:** A and B changed 00→11 on the same edge → `erro`=1, no pulses. Hold 5 cycles, then pulse `clr_erro` for one cycle → `erro`=0. A subsequent 11→01 transition → one `conta_CW`.
- **Enable gating and mid-reset:** CW steps with `enable`=0 → no pulses, and the next step after `enable`=1 decodes correctly from the tracked state. Assert `reset` in the same cycle a pulse would register → pulse suppressed, all outputs 0.
